// File: rtl/data_mem_hs.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_hs
//  Brief    : Word-addressed data memory with a valid/ready request handshake,
//             byte write strobes and a programmable read latency (1..4).
//             Reads return through a one-cycle rvalid pulse; rejected or
//             out-of-range requests raise a one-cycle err pulse.
//  Options  : DMEM_RESET_CLEAR_EN - when defined, rst_n also clears every
//             memory word; otherwise memory contents survive reset.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_hs #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  err
);

    localparam int              c_NB    = DATA_W / 8;
    // Counter only ever holds RD_LAT-1, which is at most 3.
    localparam int              c_CNT_W = 2;
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_rvalid;
    logic                   r_err;
    logic                   r_ready;

    logic [DATA_W-1:0]      r_mem [DEPTH];

    logic                   w_accept;
    logic                   w_req_in_range;
    logic                   w_rd_in_range;
    logic                   w_wr_en;

    assign w_accept       = req_valid && r_ready;
    assign w_req_in_range = ({1'b0, addr}   < c_DEPTH);
    assign w_rd_in_range  = ({1'b0, r_addr} < c_DEPTH);
    // A write lands only for an unambiguous, in-range, accepted request.
    assign w_wr_en        = w_accept && mem_write && !mem_read && w_req_in_range;

    assign req_ready = r_ready;
    assign rdata     = r_rdata;
    assign rvalid    = r_rvalid;
    assign err       = r_err;

`ifdef DMEM_RESET_CLEAR_EN
    // Storage array with byte-lane writes; reset wipes every word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int b = 0; b < c_NB; b++) begin
                if (wstrb[b]) begin
                    r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end
`else
    // Storage array with byte-lane writes; contents are not touched by reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < c_NB; b++) begin
                if (wstrb[b]) begin
                    r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end
`endif

    // Handshake FSM: accepts requests in IDLE, times reads in RD_WAIT, and
    // produces the registered rdata/rvalid/err/req_ready outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (mem_read && mem_write) begin
                            // Ambiguous command: drop it and flag it.
                            r_err <= 1'b1;
                        end else if (mem_read) begin
                            r_addr  <= addr;
                            r_cnt   <= c_CNT_W'(RD_LAT - 1);
                            r_state <= RD_WAIT;
                            r_ready <= 1'b0;
                        end else if (mem_write && !w_req_in_range) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rvalid <= 1'b1;
                        // Out-of-range reads complete on time but return zero.
                        r_rdata  <= w_rd_in_range ? r_mem[r_addr] : '0;
                        r_err    <= !w_rd_in_range;
                        r_state  <= IDLE;
                        r_ready  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_hs
//  Brief    : Directed self-checking bench for data_mem_hs (DEPTH=48, RD_LAT=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_hs;

    localparam int c_LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    data_mem_hs #(
        .DATA_W (32),
        .ADDR_W (6),
        .DEPTH  (48),
        .RD_LAT (c_LAT)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One request presented for a single cycle; returns at accept edge + 1.
    task automatic drive(input logic rd, input logic wr, input logic [5:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        req_valid = 1'b1; mem_read = rd; mem_write = wr;
        addr = a; wdata = d; wstrb = s;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        wdata = '0; wstrb = '0;
    endtask

    // Read and measure cycles from accept edge to rvalid (-1 on timeout).
    task automatic do_read(input logic [5:0] a, output int lat,
                           output logic [31:0] d, output logic e);
        lat = -1; d = '0; e = 1'b0;
        drive(1'b1, 1'b0, a, '0, '0);
        if (rvalid) lat = 0;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (rvalid) begin lat = k; d = rdata; e = err; end
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] d;
        logic        e;
        logic [7:0]  rdy_v, rv_v;
        int          nrv;
        logic [31:0] exp0;

        rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr = '0; wdata = '0; wstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready",  {31'd0, req_ready}, 32'd1);
        check("reset_rvalid", {31'd0, rvalid},    32'd0);
        check("reset_err",    {31'd0, err},       32'd0);
        check("reset_rdata",  rdata,              32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Basic write then read with full strobes.
        drive(1'b0, 1'b1, 6'd0, 32'd39, 4'hF);
        check("wr0_err", {31'd0, err}, 32'd0);
        do_read(6'd0, lat, d, e);
        check("rd0_lat",  32'(lat), 32'(c_LAT));
        check("rd0_data", d, 32'd39);
        check("rd0_err",  {31'd0, e}, 32'd0);
        @(posedge clk); #1;
        check("rd0_pulse_end", {31'd0, rvalid}, 32'd0);

        // Byte-strobe merge.
        drive(1'b0, 1'b1, 6'd1, 32'hAABBCCDD, 4'hF);
        drive(1'b0, 1'b1, 6'd1, 32'h11223344, 4'b0101);
        do_read(6'd1, lat, d, e);
        check("strb_lat",  32'(lat), 32'(c_LAT));
        check("strb_data", d, 32'hAA22CC44);

        // Zero strobe leaves the word intact; rdata holds after the pulse.
        drive(1'b0, 1'b1, 6'd1, 32'hFFFFFFFF, 4'b0000);
        check("strb0_err", {31'd0, err}, 32'd0);
        do_read(6'd1, lat, d, e);
        check("strb0_data", d, 32'hAA22CC44);
        @(posedge clk); #1;
        check("rdata_hold", rdata, 32'hAA22CC44);

        // Held req_valid across RD_WAIT: ready low for RD_LAT cycles, then a
        // second read accepted on the first IDLE cycle.
        drive(1'b0, 1'b1, 6'd2, 32'h12345678, 4'hF);
        @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b1; addr = 6'd2;
        rdy_v = '0; rv_v = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            rdy_v[i] = req_ready;
            rv_v[i]  = rvalid;
            if (i == 4) begin req_valid = 1'b0; mem_read = 1'b0; end
        end
        check("held_ready_seq",  {24'd0, rdy_v}, 32'h0000_0088);
        check("held_rvalid_seq", {24'd0, rv_v},  32'h0000_0088);
        check("held_rd2_data",   rdata, 32'h12345678);

        // Out-of-range write and read.
        drive(1'b0, 1'b1, 6'd50, 32'd53, 4'hF);
        check("oor_wr_err", {31'd0, err}, 32'd1);
        @(posedge clk); #1;
        check("oor_wr_err_end", {31'd0, err}, 32'd0);
        do_read(6'd50, lat, d, e);
        check("oor_rd_lat",  32'(lat), 32'(c_LAT));
        check("oor_rd_data", d, 32'd0);
        check("oor_rd_err",  {31'd0, e}, 32'd1);

        // Read+write together is rejected and changes nothing.
        drive(1'b0, 1'b1, 6'd3, 32'hCAFEF00D, 4'hF);
        drive(1'b1, 1'b1, 6'd3, 32'hDEADBEEF, 4'hF);
        check("both_err",   {31'd0, err},       32'd1);
        check("both_ready", {31'd0, req_ready}, 32'd1);
        nrv = 0;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (rvalid) nrv++; end
        check("both_no_rvalid", 32'(nrv), 32'd0);
        do_read(6'd3, lat, d, e);
        check("both_data", d, 32'hCAFEF00D);

        // Neither read nor write: silently ignored.
        drive(1'b0, 1'b0, 6'd4, 32'h0, 4'hF);
        check("none_err",   {31'd0, err},       32'd0);
        check("none_ready", {31'd0, req_ready}, 32'd1);

        // Reset during RD_WAIT abandons the read.
        drive(1'b1, 1'b0, 6'd0, '0, '0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_rvalid", {31'd0, rvalid},    32'd0);
        check("rst_mid_ready",  {31'd0, req_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        nrv = 0;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (rvalid) nrv++; end
        check("rst_mid_no_rvalid", 32'(nrv), 32'd0);
`ifdef DMEM_RESET_CLEAR_EN
        exp0 = 32'd0;
`else
        exp0 = 32'd39;
`endif
        do_read(6'd0, lat, d, e);
        check("rst_mem_addr0", d, exp0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
